imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle immediate sign-extender.
- Takes a 32-bit RISC-V instruction plus format select and produces the XLEN-wide immediate.
- Adds U-type, an illegal-format flag, XLEN generalisation, a pass-through tag, and a valid/ready handshake with a 2-entry skid buffer, so it can sit between fetch/decode pipeline stages.

---
 rtl/imm_gen_pipe.sv | 124 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with a valid/ready
// handshake and a 2-entry skid buffer. It accepts an instruction and a format
// select, and returns the XLEN-wide immediate plus an opaque tag.
// Optional feature macro: IMM_GEN_CSR_EN. When it is defined, imm_src=5
// decodes the CSR zimm. When it is undefined, imm_src=5 is treated as illegal.
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   if ((XLEN != 32) && (XLEN != 64)) begin : g_xlen_check
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   typedef enum logic [2:0] {
      SRC_I  = 3'd0,
      SRC_S  = 3'd1,
      SRC_B  = 3'd2,
      SRC_J  = 3'd3,
      SRC_U  = 3'd4,
      SRC_Z  = 3'd5,
      SRC_R6 = 3'd6,
      SRC_R7 = 3'd7
   } imm_src_e;

   // The opcode field plays no part in any immediate format.
   logic unused_opcode;
   assign unused_opcode = ^in_instr[6:0];

   logic [31:0]     imm32;
   logic [XLEN-1:0] ext_imm;
   logic            ext_err;

   // Build the 32-bit form of the immediate, then sign-extend it to XLEN.
   // The Z form has bit 31 clear, so sign extension also zero-extends it.
   always_comb begin
      imm32   = '0;
      ext_err = 1'b0;
      unique case (imm_src_e'(in_imm_src))
         SRC_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         SRC_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         SRC_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
         SRC_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
         SRC_U: imm32 = {in_instr[31:12], 12'b0};
`ifdef IMM_GEN_CSR_EN
         SRC_Z: imm32 = {27'b0, in_instr[19:15]};
`else
         SRC_Z: ext_err = 1'b1;
`endif
         SRC_R6, SRC_R7: ext_err = 1'b1;
         default: ext_err = 1'b1;
      endcase
      ext_imm = XLEN'($signed(imm32));
   end

   logic             k_valid;
   logic [XLEN-1:0]  k_imm;
   logic [TAG_W-1:0] k_tag;
   logic             k_err;

   logic accept;
   logic drain;

   // in_ready comes only from the skid register, so it has no path from out_ready.
   assign in_ready = !k_valid;
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;

   // Main register M drives the outputs, and skid register K holds the overflow.
   // K can only fill while M is full, so M is always the older beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_imm   <= '0;
         out_tag   <= '0;
         out_err   <= 1'b0;
         k_valid   <= 1'b0;
         k_imm     <= '0;
         k_tag     <= '0;
         k_err     <= 1'b0;
      end else if (!out_valid || drain) begin
         if (k_valid) begin
            out_valid <= 1'b1;
            out_imm   <= k_imm;
            out_tag   <= k_tag;
            out_err   <= k_err;
            if (accept) begin
               k_imm <= ext_imm;
               k_tag <= in_tag;
               k_err <= ext_err;
            end
            k_valid <= accept;
         end else if (accept) begin
            out_valid <= 1'b1;
            out_imm   <= ext_imm;
            out_tag   <= in_tag;
            out_err   <= ext_err;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         k_valid <= 1'b1;
         k_imm   <= ext_imm;
         k_tag   <= in_tag;
         k_err   <= ext_err;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and randomised bench for imm_gen_pipe. It uses an
// arithmetic reference model and an occupancy queue. A second instance covers
// XLEN=64.
module tb_imm_gen_pipe;

   localparam int unsigned TAG_W = 5;

   typedef struct {
      logic [63:0]      imm;
      logic [TAG_W-1:0] tag;
      logic             err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_instr = '0;
   logic [2:0]       in_imm_src = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      out_imm;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;

   logic             w_in_valid = 1'b0;
   logic             w_in_ready;
   logic [31:0]      w_in_instr = '0;
   logic [2:0]       w_in_imm_src = '0;
   logic [TAG_W-1:0] w_in_tag = '0;
   logic             w_out_valid;
   logic             w_out_ready = 1'b1;
   logic [63:0]      w_out_imm;
   logic [TAG_W-1:0] w_out_tag;
   logic             w_out_err;

   int checks = 0;
   int errors = 0;

   exp_t             q[$];
   logic [TAG_W-1:0] drained[$];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_imm_src(in_imm_src), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_tag(out_tag), .out_err(out_err)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
      .clk(clk), .rst(rst),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr),
      .in_imm_src(w_in_imm_src), .in_tag(w_in_tag),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_imm(w_out_imm),
      .out_tag(w_out_tag), .out_err(w_out_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic longint fld(input logic [31:0] v);
      return longint'(v);
   endfunction

   // Reference model: each immediate is a weighted sum of instruction fields.
   // The sign weight is -1 or 0.
   function automatic exp_t model(input logic [31:0] ins, input logic [2:0] src,
                                  input logic [TAG_W-1:0] tag);
      exp_t   e;
      longint s;
      longint v;
      s = ins[31] ? -64'sd1 : 64'sd0;
      v = 0;
      e.err = 1'b0;
      case (src)
         3'd0: v = s * 2048 + fld(32'(ins[30:20]));
         3'd1: v = s * 2048 + fld(32'(ins[30:25])) * 32 + fld(32'(ins[11:7]));
         3'd2: v = s * 4096 + fld(32'(ins[7])) * 2048 + fld(32'(ins[30:25])) * 32
                   + fld(32'(ins[11:8])) * 2;
         3'd3: v = s * 1048576 + fld(32'(ins[19:12])) * 4096 + fld(32'(ins[20])) * 2048
                   + fld(32'(ins[30:21])) * 2;
         3'd4: v = s * 64'sd2147483648 + fld(32'(ins[30:12])) * 4096;
`ifdef IMM_GEN_CSR_EN
         3'd5: v = fld(32'(ins[19:15]));
`endif
         default: e.err = 1'b1;
      endcase
      e.imm = e.err ? 64'd0 : 64'(v);
      e.tag = tag;
      return e;
   endfunction

   // Compare process: checks the DUT against the model queue on every cycle,
   // then applies the handshakes that the next rising edge will perform.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
         if (out_valid && q.size() != 0) begin
            chk("out_imm", 64'(out_imm), 64'(q[0].imm[31:0]));
            chk("out_tag", 64'(out_tag), 64'(q[0].tag));
            chk("out_err", 64'(out_err), 64'(q[0].err));
         end
         if (out_valid && out_ready && q.size() != 0) begin
            drained.push_back(out_tag);
            void'(q.pop_front());
         end
         if (in_valid && in_ready)
            q.push_back(model(in_instr, in_imm_src, in_tag));
      end
   end

   // Presents one beat, waits a bounded time for it to be accepted, and
   // returns 1 time unit after the accepting edge with in_valid low.
   task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [TAG_W-1:0] tag);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1; in_instr = ins; in_imm_src = src; in_tag = tag;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("accept_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #900000;
      errors++;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] lit_instr [4];
      logic [2:0]  lit_src   [4];
      logic [31:0] lit_imm   [4];
      int acc;
      int cyc;

      lit_instr = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7};
      lit_src   = '{3'd0, 3'd1, 3'd2, 3'd4};
      lit_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_imm", 64'(out_imm), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      rst = 1'b0;

      // Back-to-back stream with a latency of 1 and no bubbles
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; in_instr = lit_instr[0]; in_imm_src = lit_src[0]; in_tag = 5'd0;
      w_in_valid = 1'b1; w_in_instr = 32'hFFFFFFFF; w_in_imm_src = 3'd3; w_in_tag = 5'd4;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         chk("stream_valid", 64'(out_valid), 64'd1);
         chk("stream_imm", 64'(out_imm), 64'(lit_imm[k-1]));
         if (k < 4) begin
            in_instr = lit_instr[k]; in_imm_src = lit_src[k]; in_tag = 5'(k);
         end else begin
            in_valid = 1'b0;
         end
         if (k == 1) begin
            chk("x64_j_imm", w_out_imm, 64'hFFFFFFFFFFFFFFFE);
            chk("x64_j_tag", 64'(w_out_tag), 64'd4);
            w_in_instr = 32'h800000B7; w_in_imm_src = 3'd4; w_in_tag = 5'd5;
         end else if (k == 2) begin
            chk("x64_u_imm", w_out_imm, 64'hFFFFFFFF80000000);
            chk("x64_u_err", 64'(w_out_err), 64'd0);
            w_in_valid = 1'b0;
         end
      end

      // Illegal select
      send(32'hFFFFFFFF, 3'd7, 5'd9);
      chk("illegal_valid", 64'(out_valid), 64'd1);
      chk("illegal_err", 64'(out_err), 64'd1);
      chk("illegal_imm", 64'(out_imm), 64'd0);
      chk("illegal_tag", 64'(out_tag), 64'd9);

      // CSR zimm select
      send(32'h000F8000, 3'd5, 5'd10);
`ifdef IMM_GEN_CSR_EN
      chk("csr_imm", 64'(out_imm), 64'h1F);
      chk("csr_err", 64'(out_err), 64'd0);
`else
      chk("csr_imm", 64'(out_imm), 64'd0);
      chk("csr_err", 64'(out_err), 64'd1);
`endif

      // Backpressure: fill both entries, then hold the third beat off
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b0;
      drained.delete();
      send(32'h00100093, 3'd0, 5'd1);
      send(32'h00200093, 3'd0, 5'd2);
      in_valid = 1'b1; in_instr = 32'h00300093; in_imm_src = 3'd0; in_tag = 5'd3;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_hold_tag", 64'(out_tag), 64'd1);
         chk("bp_hold_imm", 64'(out_imm), 64'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!in_ready && cyc < 50) begin
         cyc++;
         @(negedge clk);
      end
      chk("bp_reopen", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_count", 64'(drained.size()), 64'd3);
      if (drained.size() == 3) begin
         chk("bp_order0", 64'(drained[0]), 64'd1);
         chk("bp_order1", 64'(drained[1]), 64'd2);
         chk("bp_order2", 64'(drained[2]), 64'd3);
      end

      // Reset with both entries full
      out_ready = 1'b0;
      send(32'h7FF00093, 3'd0, 5'd11);
      send(32'h80000093, 3'd0, 5'd12);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_out_imm", 64'(out_imm), 64'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 32'h00500093; in_imm_src = 3'd0; in_tag = 5'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_rst_valid", 64'(out_valid), 64'd1);
      chk("post_rst_imm", 64'(out_imm), 64'd5);
      chk("post_rst_tag", 64'(out_tag), 64'd7);
      @(posedge clk); #1;
      chk("post_rst_empty", 64'(out_valid), 64'd0);

      // Random valid/ready traffic
      acc = 0;
      cyc = 0;
      while (acc < 10000 && cyc < 60000) begin
         @(posedge clk); #1;
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         in_instr   = $urandom;
         in_imm_src = 3'($urandom_range(0, 7));
         in_tag     = 5'($urandom);
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         cyc++;
      end
      chk("random_beats", 64'(acc), 64'd10000);
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("final_empty", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
